// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation ADC controller.
package sar_pkg;

    typedef enum logic {
        IDLE,
        CONVERT
    } sar_state_t;

    localparam int unsigned SAR_WIDTH  = 8;
    localparam int unsigned SAR_SETTLE = 4;

    // MSB-only start code; returned 32 bits wide so callers slice to their width.
    function automatic logic [31:0] msb_only(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer for asynchronous board inputs; resets to 0.
module cmp_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: drives trial codes to the DAC, resolves one bit per
// SETTLE_CYCLES using the synchronized comparator, MSB first.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = SAR_WIDTH,
    parameter int unsigned SETTLE_CYCLES = SAR_SETTLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned     IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [31:0]     START_FULL = msb_only(WIDTH);
    localparam logic [WIDTH-1:0] START_CODE = START_FULL[WIDTH-1:0];
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
    localparam logic [7:0]      CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

    sar_state_t       state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [7:0]       cnt, cnt_nx;
    logic [WIDTH-1:0] dac_nx, result_nx;
    logic             busy_nx, done_nx;
    logic             cmp_s;
    logic [WIDTH-1:0] mask, kept;

    cmp_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cmp_in),
        .q     (cmp_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= IDX_TOP;
            cnt     <= '0;
            dac_out <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            dac_out <= dac_nx;
            result  <= result_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        dac_nx    = dac_out;
        result_nx = result;
        busy_nx   = busy;
        done_nx   = 1'b0;
        mask      = WIDTH'(1) << idx;
        // Trial bit survives only when the analog input is at or above the DAC.
        kept      = cmp_s ? dac_out : (dac_out & ~mask);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CONVERT;
                    dac_nx   = START_CODE;
                    idx_nx   = IDX_TOP;
                    cnt_nx   = CNT_RELOAD;
                    busy_nx  = 1'b1;
                end
            end
            CONVERT: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else if (idx != '0) begin
                    dac_nx = kept | (mask >> 1);
                    idx_nx = idx - IDX_W'(1);
                    cnt_nx = CNT_RELOAD;
                end else begin
                    dac_nx    = kept;
                    result_nx = kept;
                    done_nx   = 1'b1;
                    busy_nx   = 1'b0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with a behavioural comparator model.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, start2;
    logic [7:0] vin, vin2;
    logic       cmp_in, cmp_in2;
    logic [7:0] dac_out, result, dac_out2, result2;
    logic       busy, done, busy2, done2;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] vin;
        logic [7:0] exp;
        int         p1;
        int         p2;
        bit         trials;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    assign cmp_in  = (vin  >= dac_out);
    assign cmp_in2 = (vin2 >= dac_out2);

    sar_adc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cmp_in  (cmp_in),
        .dac_out (dac_out),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(3)) dut_s3 (
        .clk     (clk),
        .reset   (reset),
        .start   (start2),
        .cmp_in  (cmp_in2),
        .dac_out (dac_out2),
        .busy    (busy2),
        .done    (done2),
        .result  (result2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference SAR: trial code presented during step j (0 = MSB).
    function automatic logic [7:0] sar_trial(input logic [7:0] v, input int j);
        logic [7:0] code;
        logic [7:0] bitv;
        code = 8'h00;
        for (int b = 7; b > 7 - j; b--) begin
            bitv = 8'h01 << b;
            if (v >= (code | bitv)) code = code | bitv;
        end
        bitv = 8'h01 << (7 - j);
        return code | bitv;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got result 0x%0h with no request pending", result);
            end else begin
                chk("sb_result", 32'(result), 32'(sb.pop_front()));
            end
        end
    end

    task automatic run_conv(input logic [7:0] v, input logic [7:0] expv,
                            input int p1, input int p2, input bit trials);
        vin = v;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        sb.push_back(expv);
        @(posedge clk);
        for (int c = 0; c <= 32; c++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(c < 32));
            chk("done", 32'(done), 32'(c == 32));
            if (trials && (c % 4 == 0) && c < 32)
                chk("trial", 32'(dac_out), 32'(sar_trial(v, c / 4)));
            start = ((c + 1) == p1) || ((c + 1) == p2);
        end
        chk("final_result", 32'(result), 32'(expv));
        chk("final_dac", 32'(dac_out), 32'(expv));
    endtask

    initial begin
        tbl[0] = '{vin: 8'hA5, exp: 8'hA5, p1: -1, p2: -1, trials: 1'b1};
        tbl[1] = '{vin: 8'h00, exp: 8'h00, p1: -1, p2: -1, trials: 1'b0};
        tbl[2] = '{vin: 8'hFF, exp: 8'hFF, p1: -1, p2: -1, trials: 1'b1};
        tbl[3] = '{vin: 8'h69, exp: 8'h69, p1: 5,  p2: 20, trials: 1'b1};

        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        vin    = 8'h00;
        vin2   = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_dac", 32'(dac_out), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dac_s3", 32'(dac_out2), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_conv(tbl[i].vin, tbl[i].exp, tbl[i].p1, tbl[i].p2, tbl[i].trials);

        // start held high: each completion rolls straight into a new conversion
        vin = 8'h3C;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(8'h3C);
        @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c <= 32; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    chk("held_restart_dac", 32'(dac_out), 32'h80);
                    chk("held_restart_busy", 32'(busy), 32'd1);
                end
                chk("held_done", 32'(done), 32'(c == 32));
                if (c == 32) begin
                    chk("held_result", 32'(result), 32'h3C);
                    if (n < 2) sb.push_back(8'h3C);
                    else start = 1'b0;
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("held_stop_busy", 32'(busy), 32'd0);

        // reset in the middle of a conversion discards everything
        vin = 8'h77;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(8'h77);
        @(posedge clk);
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_dac", 32'(dac_out), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_conv(8'h11, 8'h11, -1, -1, 1'b1);

        // minimum settle time instance
        vin2 = 8'h5A;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk("s3_busy", 32'(busy2), 32'(c < 24));
            chk("s3_done", 32'(done2), 32'(c == 24));
            if ((c % 3 == 0) && c < 24)
                chk("s3_trial", 32'(dac_out2), 32'(sar_trial(8'h5A, c / 3)));
        end
        chk("s3_result", 32'(result2), 32'h5A);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d pending requests expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
